// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

    // Registered owner of the port in the previous cycle.
    typedef enum logic [1:0] {
        IDLE,
        CORE,
        EXT
    } arb_state_t;

    // Tag carried with each read so the returning data reaches the right requester.
    typedef enum logic {
        OWN_CORE,
        OWN_EXT
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    // Writes strobe only the requested bytes; reads always fetch the full word.
    function automatic logic [3:0] mem_en_of(input logic we, input logic [3:0] be);
        return we ? be : BE_ALL;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the external requester was refused.
// Latency: count updates one cycle after the refused/granted cycle.
// Backpressure: none; sat tells the arbiter to force the next ext grant.
// Ports: clk, rst_n, ext_req, ext_gnt in; cnt, sat out.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 8,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_req,
    input  logic             ext_gnt,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = (cnt == CNT_W'(STARVE_MAX - 1));

    // Any grant or a dropped request breaks the starvation run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ext_req && !ext_gnt) begin
            if (!sat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/external arbiter for a shared single-port data memory; core has priority.
// Latency: grant and memory drive are combinational; read data returns one cycle after grant.
// Backpressure: core_stall holds the core's MEM stage on a forced ext beat; ext waits for ext_gnt.
// Ports: clk, rst_n; core_* request/stall/rdata; ext_* request/gnt/rvalid/rdata;
//        mem_* drive to the memory, mem_dout back from it.
// Option: define DMEM_ARB_LOCK_EN to add ext_lock, letting ext hold the port across beats.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic [31:0]       core_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [3:0]        ext_be,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              ext_lock,
`endif
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [31:0]       ext_rdata,
    output logic              mem_we,
    output logic [3:0]        mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    arb_state_t state_q, state_d;
    logic       req_c, req_e;
    logic       gnt_core, gnt_ext;
    logic       force_ext, lock_keep, starve_sat;
    logic [$clog2(STARVE_MAX + 1)-1:0] starve_cnt;

    logic       rd_vld_q;
    owner_t     rd_own_q;
    logic [31:0] core_rdata_q, ext_rdata_q;

    // Requests are masked while reset is held so every output sits at its idle value.
    assign req_c = core_req & rst_n;
    assign req_e = ext_req & rst_n;

    // A starved ext wins once; the EXT-state check keeps it to a single beat
    // even when STARVE_MAX is so small that the counter is always saturated.
    assign force_ext = req_e & starve_sat & (state_q != EXT);

`ifdef DMEM_ARB_LOCK_EN
    assign lock_keep  = (state_q == EXT) & ext_lock & req_e;
    assign core_stall = gnt_ext & (req_c | ext_lock);
`else
    assign lock_keep  = 1'b0;
    assign core_stall = gnt_ext & req_c;
`endif

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .ext_req (req_e),
        .ext_gnt (gnt_ext),
        .cnt     (starve_cnt),
        .sat     (starve_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state is whoever owns the port this cycle.
    always_comb begin
        gnt_core = 1'b0;
        gnt_ext  = 1'b0;
        state_d  = IDLE;
        if (req_e && (!req_c || force_ext || lock_keep)) begin
            gnt_ext = 1'b1;
            state_d = EXT;
        end else if (req_c) begin
            gnt_core = 1'b1;
            state_d  = CORE;
        end
    end

    assign ext_gnt  = gnt_ext;
    assign mem_addr = gnt_ext ? ext_addr  : core_addr;
    assign mem_din  = gnt_ext ? ext_wdata : core_wdata;
    assign mem_we   = gnt_ext ? ext_we    : (gnt_core & core_we);
    assign mem_en   = gnt_ext  ? mem_en_of(ext_we, ext_be)   :
                      gnt_core ? mem_en_of(core_we, core_be) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_own_q <= OWN_CORE;
        end else begin
            rd_vld_q <= (gnt_core & ~core_we) | (gnt_ext & ~ext_we);
            rd_own_q <= gnt_ext ? OWN_EXT : OWN_CORE;
        end
    end

    // Read data bypasses the holding registers on the return cycle so it is
    // visible one cycle after grant, then is held until the next owned read.
    assign ext_rvalid = rd_vld_q & (rd_own_q == OWN_EXT);
    assign core_rdata = (rd_vld_q && rd_own_q == OWN_CORE) ? mem_dout : core_rdata_q;
    assign ext_rdata  = ext_rvalid ? mem_dout : ext_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            core_rdata_q <= core_rdata;
            ext_rdata_q  <= ext_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first, one-cycle-latency memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_req, core_we;
    logic [3:0]        core_be;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic              core_stall;
    logic [31:0]       core_rdata;
    logic              ext_req, ext_we;
    logic [3:0]        ext_be;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic              ext_lock;
`endif
    logic              ext_gnt, ext_rvalid;
    logic [31:0]       ext_rdata;
    logic              mem_we;
    logic [3:0]        mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_be    (core_be),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_be     (ext_be),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .ext_lock   (ext_lock),
`endif
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_we     (mem_we),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Word-addressed memory, write-first: a write also returns the merged word.
    logic [31:0] mem [0:1023];
    logic [31:0] mw;
    always @(posedge clk) begin
        if (mem_en != 4'b0000) begin
            mw = mem[mem_addr[11:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_en[b]) mw[b*8 +: 8] = mem_din[b*8 +: 8];
                end
            end
            mem[mem_addr[11:2]] <= mw;
            mem_dout <= mw;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [3:0] be,
                              input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        core_req   = req;
        core_we    = we;
        core_be    = be;
        core_addr  = addr;
        core_wdata = wdata;
    endtask

    task automatic drive_ext(input logic req, input logic we, input logic [3:0] be,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        ext_req   = req;
        ext_we    = we;
        ext_be    = be;
        ext_addr  = addr;
        ext_wdata = wdata;
    endtask

    initial begin
        // Reset held with both requesters active: outputs must stay idle.
        rst_n = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        ext_lock = 1'b0;
`endif
        drive_core(1'b1, 1'b0, 4'hF, 12'h010, 32'h0);
        drive_ext (1'b1, 1'b0, 4'hF, 12'h020, 32'h0);
        #3;
        chk("rst_ext_gnt",    32'(ext_gnt),    32'h0);
        chk("rst_core_stall", 32'(core_stall), 32'h0);
        chk("rst_mem_we",     32'(mem_we),     32'h0);
        chk("rst_mem_en",     32'(mem_en),     32'h0);
        chk("rst_ext_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rst_core_rdata", core_rdata,      32'h0);
        chk("rst_ext_rdata",  ext_rdata,       32'h0);
        chk("rst_starve",     32'(dut.starve_cnt), 32'h0);
        cyc();
        cyc();
        drive_core(1'b0, 1'b0, 4'hF, 12'h010, 32'h0);
        drive_ext (1'b0, 1'b0, 4'hF, 12'h020, 32'h0);
        rst_n = 1'b1;

        // Preload 0x010 through the ext port with the core idle.
        drive_ext(1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
        #2;
        chk("pre_ext_gnt", 32'(ext_gnt), 32'h1);
        chk("pre_mem_we",  32'(mem_we),  32'h1);
        cyc();
        drive_ext(1'b0, 1'b0, 4'hF, 12'h000, 32'h0);

        // Core-only read.
        drive_core(1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
        #2;
        chk("crd_stall",    32'(core_stall), 32'h0);
        chk("crd_mem_en",   32'(mem_en),     32'hF);
        chk("crd_mem_addr", 32'(mem_addr),   32'h010);
        chk("crd_ext_gnt",  32'(ext_gnt),    32'h0);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("crd_rdata",     core_rdata,      32'hDEADBEEF);
        chk("crd_stall2",    32'(core_stall), 32'h0);
        chk("crd_no_rvalid", 32'(ext_rvalid), 32'h0);
        chk("idle_mem_en",   32'(mem_en),     32'h0);
        cyc();

        // Ext full-word write, then core reads it back.
        drive_ext(1'b1, 1'b1, 4'hF, 12'h020, 32'h12345678);
        #2;
        chk("ewr_gnt",      32'(ext_gnt),  32'h1);
        chk("ewr_mem_en",   32'(mem_en),   32'hF);
        chk("ewr_mem_din",  mem_din,       32'h12345678);
        chk("ewr_mem_addr", 32'(mem_addr), 32'h020);
        cyc();
        drive_ext(1'b0, 1'b0, 4'hF, 12'h000, 32'h0);
        drive_core(1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
        #2;
        chk("ewr_no_rvalid", 32'(ext_rvalid), 32'h0);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("ewr_readback", core_rdata, 32'h12345678);
        cyc();

        // Ext partial write: only the low two bytes change.
        drive_ext(1'b1, 1'b1, 4'b0011, 12'h020, 32'hAAAA5555);
        #2;
        chk("epw_mem_en", 32'(mem_en), 32'h3);
        cyc();
        drive_ext(1'b0, 1'b0, 4'hF, 12'h000, 32'h0);
        drive_core(1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("epw_readback", core_rdata, 32'h12345555);
        cyc();

        // Core write immediately followed by a read of the same word.
        drive_core(1'b1, 1'b1, 4'hF, 12'h030, 32'hCAFEF00D);
        #2;
        chk("cwr_mem_we", 32'(mem_we),     32'h1);
        chk("cwr_stall",  32'(core_stall), 32'h0);
        cyc();
        drive_core(1'b1, 1'b0, 4'h0, 12'h030, 32'h0);
        #2;
        chk("cwr_rd_mem_we", 32'(mem_we), 32'h0);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("cwr_readback", core_rdata, 32'hCAFEF00D);
        cyc();

        // Ext read with core idle; core_rdata must not move.
        drive_ext(1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
        #2;
        chk("erd_gnt",    32'(ext_gnt), 32'h1);
        chk("erd_mem_en", 32'(mem_en),  32'hF);
        cyc();
        drive_ext(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("erd_rvalid",     32'(ext_rvalid), 32'h1);
        chk("erd_rdata",      ext_rdata,       32'hDEADBEEF);
        chk("erd_core_hold",  core_rdata,      32'hCAFEF00D);
        cyc();
        #2;
        chk("erd_rvalid_off", 32'(ext_rvalid), 32'h0);
        chk("erd_rdata_hold", ext_rdata,       32'hDEADBEEF);
        cyc();

        // Simultaneous requests, core streaming: ext is forced in on the 8th cycle.
        drive_core(1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
        drive_ext (1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("stv_gnt_%0d", i),    32'(ext_gnt),        32'(i == 7));
            chk($sformatf("stv_stall_%0d", i),  32'(core_stall),     32'(i == 7));
            chk($sformatf("stv_cnt_%0d", i),    32'(dut.starve_cnt), 32'(i));
            if (i > 0) chk($sformatf("stv_crd_%0d", i), core_rdata, 32'hDEADBEEF);
            cyc();
        end
        drive_ext(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("stv_after_gnt",   32'(ext_gnt),    32'h0);
        chk("stv_after_stall", 32'(core_stall), 32'h0);
        chk("stv_after_addr",  32'(mem_addr),   32'h010);
        chk("stv_ext_rvalid",  32'(ext_rvalid), 32'h1);
        chk("stv_ext_rdata",   ext_rdata,       32'h12345555);
        chk("stv_cnt_clear",   32'(dut.starve_cnt), 32'h0);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        cyc();

`ifdef DMEM_ARB_LOCK_EN
        // Locked ext burst of four writes; core joins after the first beat.
        ext_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_ext(1'b1, 1'b1, 4'hF, ADDR_W'(12'h040 + 4 * i), 32'h1000 + i);
            if (i > 0) drive_core(1'b1, 1'b0, 4'h0, 12'h010, 32'h0);
            #2;
            chk($sformatf("lck_gnt_%0d", i),   32'(ext_gnt),    32'h1);
            chk($sformatf("lck_stall_%0d", i), 32'(core_stall), 32'h1);
            cyc();
        end
        ext_lock = 1'b0;
        drive_ext(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        #2;
        chk("lck_rel_gnt",   32'(ext_gnt),    32'h0);
        chk("lck_rel_stall", 32'(core_stall), 32'h0);
        chk("lck_rel_addr",  32'(mem_addr),   32'h010);
        cyc();
        drive_core(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        cyc();
`endif

        // Reset lands while an ext read is in flight.
        drive_ext(1'b1, 1'b0, 4'h0, 12'h020, 32'h0);
        #2;
        chk("rmr_gnt", 32'(ext_gnt), 32'h1);
        cyc();
        drive_ext(1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
        rst_n = 1'b0;
        #2;
        chk("rmr_rvalid",     32'(ext_rvalid), 32'h0);
        chk("rmr_ext_rdata",  ext_rdata,       32'h0);
        chk("rmr_core_rdata", core_rdata,      32'h0);
        chk("rmr_mem_en",     32'(mem_en),     32'h0);
        chk("rmr_stall",      32'(core_stall), 32'h0);
        cyc();
        rst_n = 1'b1;
        #2;
        chk("rmr_post_rvalid", 32'(ext_rvalid), 32'h0);
        chk("rmr_post_rdata",  ext_rdata,       32'h0);
        cyc();
        #2;
        chk("rmr_late_rvalid", 32'(ext_rvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
